// File: rtl/lynx_keyboard.sv
// PS/2 set-2 keystroke to Lynx 48K keyboard-matrix converter.
// Holds a 10x8 key-state matrix and returns the active-low column byte for the selected row.
module lynx_keyboard #(
    parameter int unsigned ROWS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       keyStrb,
    input  logic       keyPrss,
    input  logic [7:0] keyCode,
    input  logic [3:0] row,
    output logic [7:0] col,
    output logic       anyKey
);

    localparam int unsigned NROW  = 10;
    localparam int unsigned COL_W = 8;
    localparam int unsigned ROW_W = 4;
    localparam int unsigned BIT_W = 3;

    logic [COL_W-1:0] mtx_q [NROW];
    logic [COL_W-1:0] mtx_d [NROW];
    logic             lsh_q, lsh_d;
    logic             rsh_q, rsh_d;
    logic             ext_q, ext_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             any_q, any_d;

    logic [7:0]       map_c;
    logic             hit_c;
    logic [ROW_W-1:0] hit_row_c;
    logic [BIT_W-1:0] hit_bit_c;

    // Keymap lookup: {ext, code} -> {hit, row, bit}
    function automatic logic [7:0] key_map(input logic ext, input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case ({ext, code})
            9'h076: m = {1'b1, 4'd0, 3'd1};
            9'h172: m = {1'b1, 4'd0, 3'd2};
            9'h175: m = {1'b1, 4'd0, 3'd3};
            9'h058: m = {1'b1, 4'd0, 3'd4};
            9'h016: m = {1'b1, 4'd0, 3'd7};
            9'h026: m = {1'b1, 4'd1, 3'd0};
            9'h025: m = {1'b1, 4'd1, 3'd1};
            9'h024: m = {1'b1, 4'd1, 3'd2};
            9'h022: m = {1'b1, 4'd1, 3'd3};
            9'h023: m = {1'b1, 4'd1, 3'd4};
            9'h021: m = {1'b1, 4'd1, 3'd5};
            9'h01E: m = {1'b1, 4'd2, 3'd0};
            9'h015: m = {1'b1, 4'd2, 3'd1};
            9'h01C: m = {1'b1, 4'd2, 3'd2};
            9'h01A: m = {1'b1, 4'd2, 3'd3};
            9'h01D: m = {1'b1, 4'd2, 3'd4};
            9'h01B: m = {1'b1, 4'd2, 3'd5};
            9'h02E: m = {1'b1, 4'd3, 3'd0};
            9'h02D: m = {1'b1, 4'd3, 3'd1};
            9'h02B: m = {1'b1, 4'd3, 3'd2};
            9'h02A: m = {1'b1, 4'd3, 3'd3};
            9'h02C: m = {1'b1, 4'd3, 3'd4};
            9'h034: m = {1'b1, 4'd3, 3'd5};
            9'h036: m = {1'b1, 4'd4, 3'd0};
            9'h035: m = {1'b1, 4'd4, 3'd1};
            9'h033: m = {1'b1, 4'd4, 3'd2};
            9'h032: m = {1'b1, 4'd4, 3'd3};
            9'h031: m = {1'b1, 4'd4, 3'd5};
            9'h03D: m = {1'b1, 4'd5, 3'd0};
            9'h03E: m = {1'b1, 4'd5, 3'd1};
            9'h03C: m = {1'b1, 4'd5, 3'd2};
            9'h03A: m = {1'b1, 4'd5, 3'd3};
            9'h03B: m = {1'b1, 4'd5, 3'd4};
            9'h046: m = {1'b1, 4'd6, 3'd0};
            9'h043: m = {1'b1, 4'd6, 3'd1};
            9'h042: m = {1'b1, 4'd6, 3'd2};
            9'h041: m = {1'b1, 4'd6, 3'd3};
            9'h044: m = {1'b1, 4'd6, 3'd4};
            9'h045: m = {1'b1, 4'd7, 3'd0};
            9'h04D: m = {1'b1, 4'd7, 3'd1};
            9'h04B: m = {1'b1, 4'd7, 3'd2};
            9'h049: m = {1'b1, 4'd7, 3'd3};
            9'h04C: m = {1'b1, 4'd7, 3'd4};
            9'h029: m = {1'b1, 4'd8, 3'd0};
            9'h04E: m = {1'b1, 4'd8, 3'd1};
            9'h054: m = {1'b1, 4'd8, 3'd2};
            9'h04A: m = {1'b1, 4'd8, 3'd3};
            9'h052: m = {1'b1, 4'd8, 3'd4};
            9'h055: m = {1'b1, 4'd9, 3'd0};
            9'h05B: m = {1'b1, 4'd9, 3'd1};
            9'h066: m = {1'b1, 4'd9, 3'd2};
            9'h05A: m = {1'b1, 4'd9, 3'd3};
            9'h15A: m = {1'b1, 4'd9, 3'd3};
            9'h05D: m = {1'b1, 4'd9, 3'd4};
            9'h16B: m = {1'b1, 4'd9, 3'd5};
            9'h174: m = {1'b1, 4'd9, 3'd6};
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    assign map_c     = key_map(ext_q, keyCode);
    assign hit_c     = map_c[7];
    assign hit_row_c = map_c[6:3];
    assign hit_bit_c = map_c[2:0];

    // Event decode and readout next-state
    always_comb begin
        mtx_d = mtx_q;
        lsh_d = lsh_q;
        rsh_d = rsh_q;
        ext_d = ext_q;
        col_d = 8'hFF;
        any_d = 1'b0;

        if (keyStrb) begin
            if (keyCode == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                if (keyCode != 8'hF0 && keyCode != 8'hAA) begin
                    if (!ext_q && keyCode == 8'h12) begin
                        lsh_d = keyPrss;
                    end else if (!ext_q && keyCode == 8'h59) begin
                        rsh_d = keyPrss;
                    end else if (hit_c) begin
                        mtx_d[hit_row_c][hit_bit_c] = keyPrss;
                    end
                end
            end
        end
        // Shift bit is derived so one shift released while the other is held stays down
        mtx_d[0][0] = lsh_d | rsh_d;

        if (32'(row) < ROWS && 32'(row) < NROW) begin
            col_d = ~mtx_q[row];
        end
        for (int unsigned i = 0; i < NROW; i++) begin
            if (i < ROWS) begin
                any_d = any_d | (|mtx_q[i]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NROW; i++) begin
                mtx_q[i] <= '0;
            end
            lsh_q <= 1'b0;
            rsh_q <= 1'b0;
            ext_q <= 1'b0;
            col_q <= 8'hFF;
            any_q <= 1'b0;
        end else begin
            mtx_q <= mtx_d;
            lsh_q <= lsh_d;
            rsh_q <= rsh_d;
            ext_q <= ext_d;
            col_q <= col_d;
            any_q <= any_d;
        end
    end

    assign col    = col_q;
    assign anyKey = any_q;

endmodule

// File: tb/tb_lynx_keyboard.sv
// Self-checking bench for lynx_keyboard: directed vector table plus hand-written
// sequences for reset, latency and back-to-back strobes.
module tb_lynx_keyboard;

    logic       clock;
    logic       reset;
    logic       keyStrb;
    logic       keyPrss;
    logic [7:0] keyCode;
    logic [3:0] row;
    logic [7:0] col;
    logic       anyKey;

    int n_cmp;
    int n_err;

    typedef struct {
        logic       strb;
        logic       prss;
        logic [7:0] code;
        logic [3:0] row;
        logic [7:0] exp_col;
        logic       exp_any;
    } vec_t;

    vec_t vecs[$];

    lynx_keyboard #(.ROWS(10)) dut (
        .clock   (clock),
        .reset   (reset),
        .keyStrb (keyStrb),
        .keyPrss (keyPrss),
        .keyCode (keyCode),
        .row     (row),
        .col     (col),
        .anyKey  (anyKey)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] ec, input logic ea);
        n_cmp++;
        if (col !== ec || anyKey !== ea) begin
            n_err++;
            $display("FAIL %s: col=%h anyKey=%b, expected col=%h anyKey=%b", name, col, anyKey, ec, ea);
        end
    endtask

    // One strobe cycle followed by one settle cycle; samples 1 time unit after the edge
    task automatic step(input logic s, input logic p, input logic [7:0] c, input logic [3:0] r);
        keyStrb = s;
        keyPrss = p;
        keyCode = c;
        row     = r;
        @(posedge clock); #1;
        keyStrb = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic add(input logic s, input logic p, input logic [7:0] c, input logic [3:0] r,
                       input logic [7:0] ec, input logic ea);
        vec_t v;
        v.strb = s; v.prss = p; v.code = c; v.row = r; v.exp_col = ec; v.exp_any = ea;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        keyStrb = 1'b0;
        keyPrss = 1'b0;
        keyCode = 8'h00;
        row     = 4'd0;

        // Expected sequence: {strb, prss, code, row, col, anyKey}
        add(1, 1, 8'h1C, 2, 8'hFB, 1);  // make A
        add(1, 1, 8'h1C, 2, 8'hFB, 1);  // typematic repeat
        add(1, 0, 8'h1C, 2, 8'hFF, 0);  // break A
        add(1, 1, 8'hE0, 0, 8'hFF, 0);
        add(1, 1, 8'h75, 0, 8'hF7, 1);  // up
        add(1, 1, 8'h75, 0, 8'hF7, 1);  // unprefixed 75 is unmapped
        add(1, 0, 8'h75, 0, 8'hF7, 1);  // ext was cleared, so no release
        add(1, 1, 8'hE0, 0, 8'hF7, 1);
        add(1, 0, 8'h75, 0, 8'hFF, 0);
        add(1, 1, 8'h12, 0, 8'hFE, 1);  // lsh
        add(1, 1, 8'h59, 0, 8'hFE, 1);  // rsh
        add(1, 0, 8'h12, 0, 8'hFE, 1);  // rsh still held
        add(1, 0, 8'h59, 0, 8'hFF, 0);
        add(1, 1, 8'hE0, 0, 8'hFF, 0);
        add(1, 1, 8'h12, 0, 8'hFF, 0);  // fake shift
        add(1, 1, 8'hE0, 0, 8'hFF, 0);
        add(1, 1, 8'hF0, 0, 8'hFF, 0);  // F0 clears ext
        add(1, 1, 8'h75, 0, 8'hFF, 0);
        add(1, 1, 8'h5A, 9, 8'hF7, 1);  // return
        add(1, 1, 8'hE0, 9, 8'hF7, 1);
        add(1, 1, 8'h5A, 9, 8'hF7, 1);  // keypad enter, same bit
        add(1, 0, 8'h5A, 9, 8'hFF, 0);  // last event wins
        add(1, 1, 8'h29, 8, 8'hFE, 1);  // space
        add(0, 0, 8'h00, 12, 8'hFF, 1); // unimplemented row
        add(1, 0, 8'h29, 8, 8'hFF, 0);
        add(1, 1, 8'hE0, 9, 8'hFF, 0);
        add(1, 1, 8'hAA, 9, 8'hFF, 0);  // AA clears ext
        add(1, 1, 8'h6B, 9, 8'hFF, 0);
        add(1, 1, 8'hE0, 9, 8'hFF, 0);
        add(1, 1, 8'h6B, 9, 8'hDF, 1);  // left
        add(1, 1, 8'hE0, 9, 8'hDF, 1);
        add(1, 1, 8'h74, 9, 8'h9F, 1);  // right
        add(1, 1, 8'hE0, 9, 8'h9F, 1);
        add(1, 0, 8'h6B, 9, 8'hBF, 1);
        add(1, 1, 8'hE0, 9, 8'hBF, 1);
        add(1, 0, 8'h74, 9, 8'hFF, 0);
        add(1, 1, 8'h07, 0, 8'hFF, 0);  // unmapped code
        add(1, 1, 8'hE0, 0, 8'hFF, 0);
        add(1, 1, 8'h72, 0, 8'hFB, 1);  // down
        add(1, 1, 8'hE0, 0, 8'hFB, 1);
        add(1, 0, 8'h72, 0, 8'hFF, 0);
        add(1, 1, 8'h58, 0, 8'hEF, 1);  // caps
        add(1, 0, 8'h58, 0, 8'hFF, 0);
        add(1, 1, 8'hE0, 0, 8'hFF, 0);
        add(1, 1, 8'hE0, 0, 8'hFF, 0);  // repeated E0 keeps ext
        add(1, 1, 8'h75, 0, 8'hF7, 1);
        add(1, 1, 8'hE0, 0, 8'hF7, 1);
        add(1, 0, 8'h75, 0, 8'hFF, 0);

        #1;
        check("reset_async", 8'hFF, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int r = 0; r < 16; r++) begin
            row = 4'(r);
            @(posedge clock); #1;
            check($sformatf("reset_row%0d", r), 8'hFF, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].strb, vecs[i].prss, vecs[i].code, vecs[i].row);
            check($sformatf("vec%0d", i), vecs[i].exp_col, vecs[i].exp_any);
        end

        // Reset between E0 and the next code drops the prefix and clears the matrix
        step(1, 1, 8'h29, 8);
        check("pre_reset_space", 8'hFE, 1'b1);
        step(1, 1, 8'hE0, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        step(1, 1, 8'h72, 0);
        check("reset_mid_ext", 8'hFF, 1'b0);

        // Strobe on the edge where reset is still high is ignored
        reset   = 1'b1;
        keyStrb = 1'b1;
        keyPrss = 1'b1;
        keyCode = 8'h1C;
        row     = 4'd2;
        @(posedge clock); #1;
        reset   = 1'b0;
        keyStrb = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("strobe_in_reset", 8'hFF, 1'b0);

        // Back-to-back strobes on consecutive clocks
        row     = 4'd0;
        keyStrb = 1'b1;
        keyPrss = 1'b1;
        keyCode = 8'h76;
        @(posedge clock); #1;
        keyCode = 8'h58;
        @(posedge clock); #1;
        keyStrb = 1'b0;
        check("b2b_first", 8'hFD, 1'b1);
        @(posedge clock); #1;
        check("b2b_both", 8'hED, 1'b1);

        // Strobe-to-col latency is two clocks
        row     = 4'd2;
        keyStrb = 1'b1;
        keyPrss = 1'b1;
        keyCode = 8'h1C;
        @(posedge clock); #1;
        keyStrb = 1'b0;
        check("latency_1clk", 8'hFF, 1'b1);
        @(posedge clock); #1;
        check("latency_2clk", 8'hFB, 1'b1);

        // Row change is visible after one clock
        row = 4'd0;
        @(posedge clock); #1;
        check("row_switch", 8'hED, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lynx_keyboard.md
# lynx_keyboard

PS/2 set-2 keystroke to Lynx keyboard-matrix converter. Sits between the SiDi/MiST `user_io` key interface (`key_strobe`/`key_pressed`/`key_code`) and the Lynx I/O decode inside `main`. Keeps a 10×8 key-state matrix updated from keystroke events and returns the active-low column byte for the row the CPU selects.

## Interface
- `ROWS`, default 10: number of implemented matrix rows. Rows ≥ `ROWS` read as all-released.
- `clock`  in  1  system clock, 24 MHz domain of `user_io`.
- `reset`  in  1  asynchronous, active-high; clears all key state.
- `keyStrb`  in  1  one-clock pulse: a new keystroke event is valid on `keyPrss`/`keyCode`.
- `keyPrss`  in  1  1 = make, 0 = break. Qualified by `keyStrb`.
- `keyCode`  in  8  PS/2 set-2 code. Qualified by `keyStrb`.
- `row`  in  4  matrix row select, from CPU address A11..A8 on a keyboard port read.
- `col`  out  8  active-low column data for `row`; 0 = key down.
- `anyKey`  out  1  1 while any matrix bit is set.
- `Already decided`: one clock; reset is asynchronous and active-high. Ports are named `clock` and `reset`.

## Operation
- Key state: `mtx[0..9][7:0]`, 1 = pressed, plus flags `lsh` and `rsh` and `ext`.
- `keyStrb` is sampled on every clock edge. No clock enable is used, so single-cycle strobes are never missed.
- Event decode on `keyStrb`:
  - `keyCode`=E0: set `ext`. No matrix change. Consecutive E0s leave `ext` set.
  - `keyCode`=F0 or AA: ignored. `ext` is cleared.
  - Any other code: look up {`ext`,`keyCode`}. If mapped, set or clear the target bit per `keyPrss`. Unmapped codes are ignored. `ext` is cleared in both cases.
- Shift handling:
  - 12 updates `lsh`; 59 updates `rsh`.
  - `mtx[0][0]` = `lsh` | `rsh`, so releasing one shift while the other is held keeps Shift down.
  - E0 12 and E0 59 (fake shifts) are ignored.
- Fixed keymap entries (row.bit):
  - Shift → 0.0
  - Esc 76 → 0.1
  - E0 72 (down) → 0.2
  - E0 75 (up) → 0.3
  - Caps 58 → 0.4
  - A 1C → 2.2
  - Space 29 → 8.0
  - Return 5A → 9.3
  - E0 5A (keypad enter) → 9.3
  - E0 6B (left) → 9.5
  - E0 74 (right) → 9.6
  - Remaining alphanumerics follow the Lynx 48K matrix chart in the block's keymap case table.
- Two keys mapped to the same bit share it. The last event wins (no reference counting), except Shift, which uses the flags above.
- Make of an already-pressed key (typematic repeat) leaves the state unchanged.
- Readout:
  - `col` = ~`mtx[row]` for `row` < `ROWS`, else FF.
  - `anyKey` = OR of all matrix bits.

## Timing
- Reset values: `mtx` all 0, `lsh`=`rsh`=`ext`=0, `col`=FF, `anyKey`=0.
- `mtx` is updated on the clock edge that samples `keyStrb`.
- `col` and `anyKey` are registered: they reflect a new event or a new `row` one clock later, so total latency from strobe to `col` is 2 clocks.
- `row` change → `col` valid on the next edge. The CPU I/O read holds `row` for at least 2 clocks.
- Reset asserted mid-sequence (E0 seen, next code pending): `ext` is cleared and the following code is treated as non-extended.
- A strobe in the same cycle that reset deasserts: the strobe is ignored (reset dominates that edge).
- Strobes on consecutive clocks are all processed in order, with no drop.

## Test plan
- Reset then `row`=0..15: `col`=FF for every row, `anyKey`=0.
- Strobe make 1C, `row`=2 → `col`=FB within 2 clocks, `anyKey`=1. Strobe break 1C → `col`=FF, `anyKey`=0.
- Strobe E0 then make 75, `row`=0 → `col`=F7. Make 75 with no E0 prefix → no change to row 0; `ext` is clear afterwards.
- Make 12, make 59, break 12, `row`=0 → `col`=FE. Then break 59 → `col`=FF. Also: E0 then make 12 → `col` unchanged.
- Make 5A and make E0 5A, break 5A, `row`=9 → `col`=FF (last event wins). Make 29, `row`=8 → FE. Then `row`=12 → FF.
- Strobe E0, assert `reset` for 1 clock, release, make 72 → row 0 unchanged (FF) and no bit set anywhere. Back-to-back strobes make 76, make 58 on consecutive clocks, `row`=0 → `col`=ED.
